// File: rtl/frogger_play_core_if.sv
// Gameplay bus of the Frogger play core.
// Carries the sync inputs and their delayed copies, the four movement
// buttons, the tile-type lookup under the frog, and the game state
// outputs (pixel counts, frog tile, packed car tiles, collision, score).
//   master : the surrounding top level / stimulus side (drives i_*, reads o_*)
//   slave  : the play core itself (reads i_*, drives o_*)
// All signals are plain levels sampled on the core's rising clock edge;
// there is no valid/ready handshake on this bus.
interface frogger_play_core_if #(
    parameter int NUM_CARS = 10
);
    logic                    i_HSync;
    logic                    i_VSync;
    logic                    i_Up_Mvt;
    logic                    i_Down_Mvt;
    logic                    i_Left_Mvt;
    logic                    i_Right_Mvt;
    logic [2:0]              i_Bitmap_Data;
    logic                    o_HSync;
    logic                    o_VSync;
    logic [9:0]              o_Col_Count;
    logic [9:0]              o_Row_Count;
    logic [5:0]              o_Frogger_X;
    logic [5:0]              o_Frogger_Y;
    logic [6*NUM_CARS-1:0]   o_Car_X;
    logic [6*NUM_CARS-1:0]   o_Car_Y;
    logic                    o_Collided;
    logic [6:0]              o_Score;

    modport master (
        output i_HSync, i_VSync, i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt,
        output i_Bitmap_Data,
        input  o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frogger_X, o_Frogger_Y,
        input  o_Car_X, o_Car_Y, o_Collided, o_Score
    );

    modport slave (
        input  i_HSync, i_VSync, i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt,
        input  i_Bitmap_Data,
        output o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Frogger_X, o_Frogger_Y,
        output o_Car_X, o_Car_Y, o_Collided, o_Score
    );
endinterface

// File: rtl/frogger_play_core.sv
// Frogger gameplay core.
// Turns incoming H/V sync pulses into pixel column/row counters (tile
// index is count[9:5], 32-pixel tiles), moves the frog on the tile grid
// from button rising edges, steps a bank of lane cars once per slow tick,
// detects frog/car collisions and keeps a 0..99 score.
// Ports:
//   i_Clk   : pixel clock
//   i_Rst_L : synchronous active-low reset
//   bus     : frogger_play_core_if.slave (syncs, buttons, tile type in;
//             delayed syncs, counts, frog/car tiles, collision, score out)
module frogger_play_core #(
    parameter int                    TOTAL_COLS    = 800,
    parameter int                    TOTAL_ROWS    = 525,
    parameter int                    GAME_WIDTH    = 20,
    parameter int                    GAME_HEIGHT   = 15,
    parameter int                    NUM_CARS      = 10,
    parameter logic [6*NUM_CARS-1:0] CAR_SPEED     = {10{6'd1}},
    parameter logic [NUM_CARS-1:0]   CAR_DIRECTION = 10'b1010101010,
    parameter int                    MAX_X         = 20,
    parameter int                    SLOW_COUNT    = 2000000,
    parameter int                    START_X       = 10,
    parameter int                    START_Y       = 14
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    frogger_play_core_if.slave    bus
);

    localparam logic [2:0] TILE_WATER = 3'd2;
    localparam logic [2:0] TILE_LILY  = 3'd4;

    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic [9:0]            col_q, col_d;
    logic [9:0]            row_q, row_d;
    logic [3:0]            btn_q, btn_d;       // {up, down, left, right}
    logic [3:0]            btn_rise;
    logic [5:0]            frog_x_q, frog_x_d;
    logic [5:0]            frog_y_q, frog_y_d;
    logic [6:0]            score_q, score_d;
    logic                  collided_q, collided_d;
    logic [31:0]           slow_q, slow_d;
    logic                  car_tick;
    logic [5:0]            car_x_q [NUM_CARS];
    logic [5:0]            car_x_d [NUM_CARS];
    logic [6:0]            car_sum [NUM_CARS];
    logic [6:0]            car_spd [NUM_CARS];
    logic [6*NUM_CARS-1:0] car_x_flat;
    logic [6*NUM_CARS-1:0] car_y_flat;

    // Sync delay and pixel counters. A VSync rising edge restarts the frame.
    always_comb begin
        hsync_d = bus.i_HSync;
        vsync_d = bus.i_VSync;
        col_d   = col_q + 10'd1;
        row_d   = row_q;
        if (!vsync_q && bus.i_VSync) begin
            col_d = 10'd0;
            row_d = 10'd0;
        end else if (col_q == 10'(TOTAL_COLS - 1)) begin
            col_d = 10'd0;
            row_d = (row_q == 10'(TOTAL_ROWS - 1)) ? 10'd0 : row_q + 10'd1;
        end
    end

    // Frog movement and lily-pad / water / collision events.
    always_comb begin
        btn_d    = {bus.i_Up_Mvt, bus.i_Down_Mvt, bus.i_Left_Mvt, bus.i_Right_Mvt};
        btn_rise = btn_d & ~btn_q;
        frog_x_d = frog_x_q;
        frog_y_d = frog_y_q;
        score_d  = score_q;
        if (collided_q || bus.i_Bitmap_Data == TILE_WATER) begin
            frog_x_d = 6'(START_X);
            frog_y_d = 6'(START_Y);
        end else if (bus.i_Bitmap_Data == TILE_LILY) begin
            // Respawning on the same edge moves the frog off the pad, so a
            // single entry scores once.
            if (score_q < 7'd99) begin
                score_d = score_q + 7'd1;
            end
            frog_x_d = 6'(START_X);
            frog_y_d = 6'(START_Y);
        end else if (btn_rise[3]) begin
            if (frog_y_q != 6'd0) frog_y_d = frog_y_q - 6'd1;
        end else if (btn_rise[2]) begin
            if (frog_y_q != 6'(GAME_HEIGHT - 1)) frog_y_d = frog_y_q + 6'd1;
        end else if (btn_rise[1]) begin
            if (frog_x_q != 6'd0) frog_x_d = frog_x_q - 6'd1;
        end else if (btn_rise[0]) begin
            if (frog_x_q != 6'(GAME_WIDTH - 1)) frog_x_d = frog_x_q + 6'd1;
        end
    end

    // Slow tick and car motion. Arithmetic is 7 bits wide so X+speed never
    // overflows before the wrap is applied.
    always_comb begin
        car_tick = (slow_q == 32'(SLOW_COUNT - 1));
        slow_d   = car_tick ? 32'd0 : slow_q + 32'd1;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_spd[i] = {1'b0, CAR_SPEED[6*i +: 6]};
            car_sum[i] = {1'b0, car_x_q[i]};
            if (car_tick) begin
                if (CAR_DIRECTION[i]) begin
                    car_sum[i] = {1'b0, car_x_q[i]} + car_spd[i];
                    if (car_sum[i] >= 7'(MAX_X)) begin
                        car_sum[i] = car_sum[i] - 7'(MAX_X);
                    end
                end else if ({1'b0, car_x_q[i]} < car_spd[i]) begin
                    car_sum[i] = {1'b0, car_x_q[i]} + 7'(MAX_X) - car_spd[i];
                end else begin
                    car_sum[i] = {1'b0, car_x_q[i]} - car_spd[i];
                end
            end
            car_x_d[i] = car_sum[i][5:0];
        end
    end

    // Collision uses the current (registered) positions, so the flag lags
    // the overlap by one cycle.
    always_comb begin
        collided_d = 1'b0;
        car_x_flat = '0;
        car_y_flat = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x_flat[6*i +: 6] = car_x_q[i];
            car_y_flat[6*i +: 6] = 6'(i + 2);
            if (frog_x_q == car_x_q[i] && frog_y_q == 6'(i + 2)) begin
                collided_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            col_q      <= 10'd0;
            row_q      <= 10'd0;
            btn_q      <= 4'd0;
            frog_x_q   <= 6'(START_X);
            frog_y_q   <= 6'(START_Y);
            score_q    <= 7'd0;
            collided_q <= 1'b0;
            slow_q     <= 32'd0;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x_q[i] <= 6'((2 * i) % MAX_X);
            end
        end else begin
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            col_q      <= col_d;
            row_q      <= row_d;
            btn_q      <= btn_d;
            frog_x_q   <= frog_x_d;
            frog_y_q   <= frog_y_d;
            score_q    <= score_d;
            collided_q <= collided_d;
            slow_q     <= slow_d;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x_q[i] <= car_x_d[i];
            end
        end
    end

    assign bus.o_HSync     = hsync_q;
    assign bus.o_VSync     = vsync_q;
    assign bus.o_Col_Count = col_q;
    assign bus.o_Row_Count = row_q;
    assign bus.o_Frogger_X = frog_x_q;
    assign bus.o_Frogger_Y = frog_y_q;
    assign bus.o_Car_X     = car_x_flat;
    assign bus.o_Car_Y     = car_y_flat;
    assign bus.o_Collided  = collided_q;
    assign bus.o_Score     = score_q;

endmodule

// File: tb/tb_frogger_play_core.sv
module tb_frogger_play_core;

    localparam int COLS     = 50;
    localparam int ROWS     = 30;
    localparam int NCARS    = 10;
    localparam int SLOW     = 4;
    localparam int MAXX     = 20;
    localparam int SX       = 10;
    localparam int SY       = 14;
    localparam logic [6*NCARS-1:0] SPEEDS = {10{6'd1}};
    localparam logic [NCARS-1:0]   DIRS   = 10'b1010101010;

    logic clk;
    logic rst_l;
    int   n_checks;
    int   n_fail;

    frogger_play_core_if #(.NUM_CARS(NCARS)) bus ();

    frogger_play_core #(
        .TOTAL_COLS(COLS), .TOTAL_ROWS(ROWS), .NUM_CARS(NCARS),
        .CAR_SPEED(SPEEDS), .CAR_DIRECTION(DIRS), .MAX_X(MAXX),
        .SLOW_COUNT(SLOW), .START_X(SX), .START_Y(SY)
    ) dut (
        .i_Clk(clk),
        .i_Rst_L(rst_l),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cars are a closed-form function of the number of ticks since reset;
    // pixel counts are a linear pixel index since the last frame start.
    int m_pix, m_edges, m_ticks, m_fx, m_fy, m_score;
    bit m_coll, m_hs, m_vs, m_valid;
    bit [3:0] m_prev;

    function automatic int model_car_x(input int i, input int ticks);
        logic [6*NCARS-1:0] spd_v;
        int s, v;
        spd_v = SPEEDS;
        s = int'(spd_v[6*i +: 6]);
        v = DIRS[i] ? (2 * i) % MAXX + s * ticks : (2 * i) % MAXX - s * ticks;
        return ((v % MAXX) + MAXX) % MAXX;
    endfunction

    always @(posedge clk) begin
        bit [3:0] btn;
        bit [3:0] rise;
        bit coll_n;
        btn = {bus.i_Up_Mvt, bus.i_Down_Mvt, bus.i_Left_Mvt, bus.i_Right_Mvt};
        if (!rst_l) begin
            m_pix = 0; m_edges = 0; m_ticks = 0;
            m_fx = SX; m_fy = SY; m_score = 0;
            m_coll = 0; m_prev = 4'd0;
            m_hs = 0; m_vs = 0;
        end else begin
            coll_n = 0;
            for (int i = 0; i < NCARS; i++)
                if (model_car_x(i, m_ticks) == m_fx && i + 2 == m_fy) coll_n = 1;
            rise = btn & ~m_prev;
            if (m_coll || bus.i_Bitmap_Data == 3'd2) begin
                m_fx = SX; m_fy = SY;
            end else if (bus.i_Bitmap_Data == 3'd4) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
                m_fx = SX; m_fy = SY;
            end else if (rise[3]) begin
                if (m_fy > 0) m_fy--;
            end else if (rise[2]) begin
                if (m_fy < 14) m_fy++;
            end else if (rise[1]) begin
                if (m_fx > 0) m_fx--;
            end else if (rise[0]) begin
                if (m_fx < 19) m_fx++;
            end
            m_pix = (!m_vs && bus.i_VSync) ? 0 : (m_pix + 1) % (COLS * ROWS);
            m_edges++;
            m_ticks = m_edges / SLOW;
            m_coll = coll_n;
            m_prev = btn;
            m_hs = bus.i_HSync;
            m_vs = bus.i_VSync;
        end
        m_valid = 1;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("hsync", int'(bus.o_HSync), int'(m_hs));
            check("vsync", int'(bus.o_VSync), int'(m_vs));
            check("col", int'(bus.o_Col_Count), m_pix % COLS);
            check("row", int'(bus.o_Row_Count), m_pix / COLS);
            check("frog_x", int'(bus.o_Frogger_X), m_fx);
            check("frog_y", int'(bus.o_Frogger_Y), m_fy);
            check("collided", int'(bus.o_Collided), int'(m_coll));
            check("score", int'(bus.o_Score), m_score);
            for (int i = 0; i < NCARS; i++) begin
                check($sformatf("car%0d_x", i), int'(bus.o_Car_X[6*i +: 6]), model_car_x(i, m_ticks));
                check($sformatf("car%0d_y", i), int'(bus.o_Car_Y[6*i +: 6]), i + 2);
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        int hc;
        hc = 0;
        bus.i_HSync = 1'b0;
        forever begin
            @(negedge clk);
            hc = (hc + 1) % 37;
            bus.i_HSync = (hc < 4);
        end
    end

    // One button pulse: held for one clock, released for one clock.
    task automatic press(input logic [3:0] b);
        {bus.i_Up_Mvt, bus.i_Down_Mvt, bus.i_Left_Mvt, bus.i_Right_Mvt} = b;
        @(negedge clk);
        {bus.i_Up_Mvt, bus.i_Down_Mvt, bus.i_Left_Mvt, bus.i_Right_Mvt} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_frog_x"}, int'(bus.o_Frogger_X), 10);
        check({tag, "_frog_y"}, int'(bus.o_Frogger_Y), 14);
        check({tag, "_score"}, int'(bus.o_Score), 0);
        check({tag, "_car0_x"}, int'(bus.o_Car_X[5:0]), 0);
        check({tag, "_car1_x"}, int'(bus.o_Car_X[11:6]), 2);
        check({tag, "_car1_y"}, int'(bus.o_Car_Y[11:6]), 3);
        check({tag, "_col"}, int'(bus.o_Col_Count), 0);
        check({tag, "_row"}, int'(bus.o_Row_Count), 0);
        check({tag, "_collided"}, int'(bus.o_Collided), 0);
        check({tag, "_vsync"}, int'(bus.o_VSync), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit got;
        n_checks = 0;
        n_fail   = 0;
        rst_l    = 1'b0;
        bus.i_VSync = 1'b0;
        {bus.i_Up_Mvt, bus.i_Down_Mvt, bus.i_Left_Mvt, bus.i_Right_Mvt} = 4'b0000;
        bus.i_Bitmap_Data = 3'd1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_l = 1'b1;

        // Cars: tick every 4th edge after reset.
        repeat (3) @(negedge clk);
        check("car0_before_tick", int'(bus.o_Car_X[5:0]), 0);
        @(negedge clk);
        check("car0_left_wrap", int'(bus.o_Car_X[5:0]), 19);
        repeat (64) @(negedge clk);
        check("car1_at_19", int'(bus.o_Car_X[11:6]), 19);
        repeat (4) @(negedge clk);
        check("car1_right_wrap", int'(bus.o_Car_X[11:6]), 0);

        // Frame start, one line, one full frame.
        bus.i_VSync = 1'b1;
        @(negedge clk);
        bus.i_VSync = 1'b0;
        check("frame_col", int'(bus.o_Col_Count), 0);
        check("frame_row", int'(bus.o_Row_Count), 0);
        check("frame_vsync_out", int'(bus.o_VSync), 1);
        repeat (COLS) @(negedge clk);
        check("line_col", int'(bus.o_Col_Count), 0);
        check("line_row", int'(bus.o_Row_Count), 1);
        repeat (COLS * ROWS - COLS) @(negedge clk);
        check("wrap_col", int'(bus.o_Col_Count), 0);
        check("wrap_row", int'(bus.o_Row_Count), 0);

        // Held Up moves once.
        bus.i_Up_Mvt = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_Up_Mvt = 1'b0;
        @(negedge clk);
        check("hold_up_x", int'(bus.o_Frogger_X), 10);
        check("hold_up_y", int'(bus.o_Frogger_Y), 13);

        // Left to the wall, then one more Left is blocked.
        repeat (10) press(4'b0010);
        check("left_to_wall", int'(bus.o_Frogger_X), 0);
        press(4'b0010);
        check("left_blocked", int'(bus.o_Frogger_X), 0);

        // Up and Right together: only Up.
        press(4'b1001);
        check("up_right_x", int'(bus.o_Frogger_X), 0);
        check("up_right_y", int'(bus.o_Frogger_Y), 12);

        // Climb to car 0's lane and wait for the car to hit the frog.
        for (int a = 0; a < 200 && m_fy != 2; a++) press(4'b1000);
        check("reach_lane2", m_fy, 2);
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (bus.o_Collided) got = 1;
        end
        check("collision_seen", int'(got), 1);
        @(negedge clk);
        check("collide_respawn_x", int'(bus.o_Frogger_X), 10);
        check("collide_respawn_y", int'(bus.o_Frogger_Y), 14);
        check("collide_score", int'(bus.o_Score), 0);
        repeat (2) @(negedge clk);

        // Lily pad scores and respawns.
        press(4'b1000);
        bus.i_Bitmap_Data = 3'd4;
        @(negedge clk);
        bus.i_Bitmap_Data = 3'd1;
        check("lily_score", int'(bus.o_Score), 1);
        check("lily_respawn_y", int'(bus.o_Frogger_Y), 14);
        bus.i_Bitmap_Data = 3'd4;
        repeat (4) @(negedge clk);
        bus.i_Bitmap_Data = 3'd1;
        check("score_five", int'(bus.o_Score), 5);
        press(4'b1000);
        press(4'b1000);
        check("pre_reset_y", int'(bus.o_Frogger_Y), 12);

        // Reset mid-game.
        rst_l = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        rst_l = 1'b1;

        // Score saturation.
        bus.i_Bitmap_Data = 3'd4;
        repeat (99) @(negedge clk);
        check("score_99", int'(bus.o_Score), 99);
        @(negedge clk);
        bus.i_Bitmap_Data = 3'd1;
        check("score_sat", int'(bus.o_Score), 99);

        // Water respawns without scoring.
        press(4'b1000);
        check("pre_water_y", int'(bus.o_Frogger_Y), 13);
        bus.i_Bitmap_Data = 3'd2;
        @(negedge clk);
        bus.i_Bitmap_Data = 3'd1;
        check("water_y", int'(bus.o_Frogger_Y), 14);
        check("water_x", int'(bus.o_Frogger_X), 10);
        check("water_score", int'(bus.o_Score), 99);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
